// File: rtl/pa_issue_ctrl.sv
// Issue/hazard controller: owns the PC, checks each fetched R-type add against a
// shifting destination scoreboard, and either issues it to decode or inserts a bubble.
module pa_issue_ctrl #(
  parameter int PROG_LEN   = 10,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] LAST_PC = 32'(PROG_LEN - 1);

  typedef enum logic [1:0] {
    DEC_HOLD,
    DEC_SKIP,
    DEC_STALL,
    DEC_ISSUE
  } decision_t;

  logic [5:0]            w_op;
  logic [4:0]            w_rs;
  logic [4:0]            w_rt;
  logic [4:0]            w_rd;
  logic [5:0]            w_funct;
  logic                  w_unusedShamt;
  logic                  w_isAdd;
  logic                  w_raw;
  logic                  w_hazard;
  logic [31:0]           w_pcNext;
  decision_t             w_decision;

  logic [PIPE_DEPTH-1:0] r_sbValid;
  logic [4:0]            r_sbReg [PIPE_DEPTH];

  assign w_op          = instr[31:26];
  assign w_rs          = instr[25:21];
  assign w_rt          = instr[20:16];
  assign w_rd          = instr[15:11];
  assign w_funct       = instr[5:0];
  assign w_unusedShamt = ^instr[10:6];
  assign w_isAdd       = (w_op == 6'd0) && (w_funct == 6'b100000);
  assign w_pcNext      = (pc < LAST_PC) ? pc + 32'd1 : 32'd0;

  // r0 is hardwired, so a scoreboard entry naming it never blocks a reader
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (r_sbValid[i] && (r_sbReg[i] != 5'd0) &&
          ((r_sbReg[i] == w_rs) || (r_sbReg[i] == w_rt))) begin
        w_raw = 1'b1;
      end
    end
  end

  assign w_hazard = w_isAdd && w_raw;

  always_comb begin
    w_decision = DEC_ISSUE;
    if (!run) begin
      w_decision = DEC_HOLD;
    end else if (!w_isAdd) begin
      w_decision = DEC_SKIP;
    end else if (w_hazard) begin
      w_decision = DEC_STALL;
    end
  end

  // The scoreboard shifts every cycle, so it drains even while run is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sbValid <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_sbReg[i] <= 5'd0;
      end
    end else begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        r_sbValid[i] <= r_sbValid[i-1];
        r_sbReg[i]   <= r_sbReg[i-1];
      end
      r_sbValid[0] <= (w_decision == DEC_ISSUE);
      r_sbReg[0]   <= (w_decision == DEC_ISSUE) ? w_rd : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= 32'd0;
      issue_valid <= 1'b0;
      issue_instr <= 32'd0;
      stall       <= 1'b0;
      illegal     <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      issue_valid <= 1'b0;
      issue_instr <= 32'd0;
      stall       <= 1'b0;
      illegal     <= 1'b0;
      case (w_decision)
        DEC_HOLD: begin
        end
        DEC_SKIP: begin
          pc      <= w_pcNext;
          illegal <= 1'b1;
        end
        DEC_STALL: begin
          stall <= 1'b1;
          if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: begin
          pc          <= w_pcNext;
          issue_valid <= 1'b1;
          issue_instr <= instr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pa_issue_ctrl.sv
// Directed bench for pa_issue_ctrl: expected issued words go into a queue and a
// monitor compares them whenever issue_valid is seen; control outputs are checked inline.
module tb_pa_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        stall;
  logic        illegal;
  logic [15:0] stall_cnt;

  logic [31:0] mem [10];
  logic [31:0] expQ [$];
  int          testsRun;
  int          testsFailed;

  pa_issue_ctrl #(.PROG_LEN(10), .PIPE_DEPTH(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr       (instr),
    .pc          (pc),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .stall       (stall),
    .illegal     (illegal),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    instr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (pc == 32'(i)) instr = mem[i];
    end
  end

  function automatic logic [31:0] addOp(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'b100000};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic runVal);
    run = runVal;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    run = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 10; i++) mem[i] = 32'd0;
  endtask

  // Monitor: every issued word must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && issue_valid) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_issue: got %0h, expected no issue", issue_instr);
        end else begin
          checkOutput("issue_instr", issue_instr, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    run         = 1'b0;
    clearMem();

    // Reset state and three independent adds back-to-back
    mem[0] = addOp(5'd1, 5'd2, 5'd9);
    mem[1] = addOp(5'd3, 5'd4, 5'd5);
    mem[2] = addOp(5'd7, 5'd8, 5'd6);
    doReset();
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_valid", 32'(issue_valid), 32'd0);
    checkOutput("reset_instr", issue_instr, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    checkOutput("reset_cnt", 32'(stall_cnt), 32'd0);
    expQ.push_back(mem[0]);
    expQ.push_back(mem[1]);
    expQ.push_back(mem[2]);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1);
      checkOutput("indep_pc", pc, 32'(i));
      checkOutput("indep_valid", 32'(issue_valid), 32'd1);
      checkOutput("indep_stall", 32'(stall), 32'd0);
    end
    checkOutput("indep_cnt", 32'(stall_cnt), 32'd0);
    applyStimulus(1'b0);

    // Adjacent dependency: three bubbles with pc held at 1
    clearMem();
    mem[0] = addOp(5'd2, 5'd13, 5'd9);
    mem[1] = addOp(5'd3, 5'd9, 5'd13);
    doReset();
    expQ.push_back(mem[0]);
    expQ.push_back(mem[1]);
    applyStimulus(1'b1);
    checkOutput("adj_first_pc", pc, 32'd1);
    checkOutput("adj_first_valid", 32'(issue_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      checkOutput("adj_bubble_stall", 32'(stall), 32'd1);
      checkOutput("adj_bubble_valid", 32'(issue_valid), 32'd0);
      checkOutput("adj_bubble_pc", pc, 32'd1);
    end
    checkOutput("adj_cnt", 32'(stall_cnt), 32'd3);
    applyStimulus(1'b1);
    checkOutput("adj_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("adj_issue_pc", pc, 32'd2);
    checkOutput("adj_issue_stall", 32'(stall), 32'd0);
    applyStimulus(1'b0);

    // Distance 2, illegal skip, r0 handling, wrap-around dependency
    clearMem();
    mem[0] = addOp(5'd26, 5'd5, 5'd1);
    mem[1] = addOp(5'd6, 5'd7, 5'd2);
    mem[2] = addOp(5'd1, 5'd8, 5'd3);
    mem[3] = 32'hFFFFFFFF;
    mem[4] = addOp(5'd10, 5'd11, 5'd0);
    mem[5] = addOp(5'd0, 5'd12, 5'd14);
    mem[6] = addOp(5'd15, 5'd16, 5'd17);
    mem[7] = addOp(5'd18, 5'd19, 5'd20);
    mem[8] = addOp(5'd21, 5'd22, 5'd23);
    mem[9] = addOp(5'd24, 5'd25, 5'd26);
    doReset();
    expQ.push_back(mem[0]);
    expQ.push_back(mem[1]);
    expQ.push_back(mem[2]);
    for (int i = 4; i <= 9; i++) expQ.push_back(mem[i]);
    expQ.push_back(mem[0]);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("d2_pc_before", pc, 32'd2);
    applyStimulus(1'b1);
    checkOutput("d2_stall1", 32'(stall), 32'd1);
    applyStimulus(1'b1);
    checkOutput("d2_stall2", 32'(stall), 32'd1);
    checkOutput("d2_pc_held", pc, 32'd2);
    applyStimulus(1'b1);
    checkOutput("d2_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("d2_issue_pc", pc, 32'd3);
    checkOutput("d2_cnt", 32'(stall_cnt), 32'd2);
    applyStimulus(1'b1);
    checkOutput("ill_pulse", 32'(illegal), 32'd1);
    checkOutput("ill_pc", pc, 32'd4);
    checkOutput("ill_valid", 32'(issue_valid), 32'd0);
    applyStimulus(1'b1);
    checkOutput("ill_pulse_end", 32'(illegal), 32'd0);
    checkOutput("r0_dest_valid", 32'(issue_valid), 32'd1);
    applyStimulus(1'b1);
    checkOutput("r0_src_valid", 32'(issue_valid), 32'd1);
    checkOutput("r0_src_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    checkOutput("wrap_pc", pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      checkOutput("wrap_stall", 32'(stall), 32'd1);
      checkOutput("wrap_pc_held", pc, 32'd0);
    end
    checkOutput("wrap_cnt", 32'(stall_cnt), 32'd5);
    applyStimulus(1'b1);
    checkOutput("wrap_issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("wrap_issue_pc", pc, 32'd1);
    applyStimulus(1'b0);

    // run dropped mid-stall: scoreboard drains, pending add issues at once
    clearMem();
    mem[0] = addOp(5'd2, 5'd13, 5'd9);
    mem[1] = addOp(5'd3, 5'd9, 5'd13);
    doReset();
    expQ.push_back(mem[0]);
    expQ.push_back(mem[1]);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("run_pre_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      checkOutput("run_off_stall", 32'(stall), 32'd0);
      checkOutput("run_off_valid", 32'(issue_valid), 32'd0);
      checkOutput("run_off_pc", pc, 32'd1);
    end
    applyStimulus(1'b1);
    checkOutput("run_resume_valid", 32'(issue_valid), 32'd1);
    checkOutput("run_resume_pc", pc, 32'd2);
    checkOutput("run_resume_cnt", 32'(stall_cnt), 32'd1);
    applyStimulus(1'b0);

    // Asynchronous reset between edges during a stall
    doReset();
    expQ.push_back(mem[0]);
    expQ.push_back(mem[0]);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("arst_pre_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_pc", pc, 32'd0);
    checkOutput("arst_stall", 32'(stall), 32'd0);
    checkOutput("arst_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("arst_valid", 32'(issue_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1);
    checkOutput("arst_first_pc", pc, 32'd1);
    checkOutput("arst_first_valid", 32'(issue_valid), 32'd1);
    checkOutput("arst_first_stall", 32'(stall), 32'd0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
